decode: RTL and testbench
=========================

Name: decode

Overview:
- Instruction-decode stage directly downstream of fetch.
- Consumes fetch's 16-bit `inst` each cycle and decodes it into control signals and a sign-extended immediate.
- Reads source operands from an internal 8-entry register file, which is written by the write-back stage.
- Results are presented to execute through one pipeline register; the block also detects load-use hazards and requests a fetch stall.

Parameters:
- DATA_W, 16, register / operand width.
- NREG, 8, register-file entries (address width 3); r0 reads as 0 and ignores writes.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- inst  input  16  instruction from fetch.
- inst_valid  input  1  inst is meaningful this cycle.
- stall  input  1  downstream stall; hold the entire output register.
- flush  input  1  branch/jump taken downstream; kill the instruction being decoded.
- wb_en  input  1  register-file write enable.
- wb_addr  input  3  write address.
- wb_data  input  DATA_W  write data.
- valid_o  output  1  output register holds a live instruction.
- op_o  output  4  opcode.
- alu_fn_o  output  3  ALU function.
- rd_o  output  3  destination register.
- rs_data_o  output  DATA_W  operand A.
- rt_data_o  output  DATA_W  operand B (rd value for SW/BEQ).
- imm_o  output  DATA_W  sign-extended immediate.
- reg_write_o  output  1  control flag.
- mem_read_o  output  1  control flag.
- mem_write_o  output  1  control flag.
- branch_o  output  1  control flag.
- jump_o  output  1  control flag.
- halt_o  output  1  control flag.
- illegal_o  output  1  control flag.
- hazard_o  output  1  combinational stall request to fetch.

Behaviour:
- Instruction format: [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt, [2:0] fn.
- Opcodes:
  - 0 R-type: alu_fn = fn (0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 slt); reg_write = 1.
  - 1 ADDI: imm = sext([5:0]); reg_write = 1; alu_fn = add.
  - 2 LW: rd = mem[rs + sext([5:0])]; mem_read = 1; reg_write = 1.
  - 3 SW: mem_write = 1; rt_data_o = R[rd].
  - 4 BEQ: compare R[rd], R[rs]; imm = sext([5:0]); branch = 1.
  - 5 JMP: imm = sext([11:0]); jump = 1.
  - 6 LI: imm = sext([8:0]); reg_write = 1.
  - F HALT: halt = 1.
  - 7–E: illegal_o = 1, all other control flags 0, valid_o = 1.
- Latency: one cycle, inst to registered outputs.
- Register-file read is combinational with write-through bypass: if wb_en is high and wb_addr equals a nonzero read address, the read returns wb_data in the same cycle.
- Register file is written on the rising edge; writes to r0 are discarded. Register-file contents are NOT cleared by reset; only r0 is guaranteed.
- Reset: all outputs and the pipeline register go to 0; FSM goes to RUN.
- FSM states:
  - RUN: normal decode.
  - HALTED: entered on the edge that latches a valid HALT. Once in HALTED, valid_o = 0 on every following cycle, hazard_o = 0, inputs are ignored except write-back. Leaves HALTED only on reset.
  - halt_o stays 1 for exactly the one cycle HALT is presented.
- Update priority at each rising edge (rst high):
  1. stall: hold all outputs unchanged.
  2. flush: valid_o ← 0, control flags ← 0.
  3. hazard_o: insert bubble, valid_o ← 0.
  4. inst_valid: latch the decoded instruction, valid_o ← 1.
  5. otherwise: valid_o ← 0.
- hazard_o = valid_o & mem_read_o & (rd_o ≠ 0) & inst_valid & ~flush & (state = RUN) & (rd_o matches a source the incoming instruction actually reads).
  - Sources per type: R-type reads rs, rt; ADDI/LW read rs; SW/BEQ read rs, rd; JMP/LI/HALT read none.
- Simultaneous stall & hazard: stall wins, but hazard_o is still driven so fetch also holds.
- A flush in the same cycle as a HALT input prevents entry to HALTED.
- Reset asserted mid-operation clears everything asynchronously in the same cycle, regardless of clk.

Test Plan:
- Reset, then rst = 1 with inst = 0x1245 (ADDI r1, r1, 5) valid -> next edge: valid_o = 1, op_o = 1, rd_o = 1, imm_o = 0x0005, reg_write_o = 1.
- wb_en = 1, wb_addr = 2, wb_data = 0xBEEF in the same cycle as inst = 0x0290 (add r1, r2, r2) -> rs_data_o = rt_data_o = 0xBEEF (bypass); a write to r0 followed by a read of r0 yields 0x0000.
- inst = 0x223F (LW r1, -1(r0)), then 0x0248 (add r1, r1, r1) -> hazard_o = 1 in the second cycle, next valid_o = 0 (bubble); add decodes on the following edge with hazard_o = 0.
- inst = 0x5FFE (JMP) -> imm_o = 0xFFFE, jump_o = 1; flush asserted next cycle with a valid ADDI input -> valid_o = 0, all flags 0.
- stall = 1 for 3 cycles with changing inst -> all outputs frozen at their prior values.
- inst = 0xF000 -> halt_o = 1 for one cycle, then valid_o stays 0 for 5 valid inputs; a pulse rst = 0 mid-cycle immediately zeroes outputs, and decode resumes after rst = 1.

Source files
------------

// File: rtl/decode.sv
// Instruction-decode stage: 16-bit instruction to registered control/operands,
// with an 8-entry write-through register file and load-use hazard detection.
module decode #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       inst,
  input  logic              inst_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              valid_o,
  output logic [3:0]        op_o,
  output logic [2:0]        alu_fn_o,
  output logic [2:0]        rd_o,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic              reg_write_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              branch_o,
  output logic              jump_o,
  output logic              halt_o,
  output logic              illegal_o,
  output logic              hazard_o
);

  typedef enum logic {RUN, HALTED} state_t;

  typedef struct packed {
    logic              valid;
    logic [3:0]        op;
    logic [2:0]        alu_fn;
    logic [2:0]        rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic              halt;
    logic              illegal;
  } dec_t;

  state_t state_q, state_d;
  dec_t   out_q, out_d, dec;

  logic [DATA_W-1:0] regs [NREG];
  logic [3:0]        op;
  logic [2:0]        rd_a, rs_a, rt_a;
  logic [DATA_W-1:0] rd_val, rs_val, rt_val;
  logic              reads_rs, reads_rt, reads_rd, src_match, hazard;

  assign op   = inst[15:12];
  assign rd_a = inst[11:9];
  assign rs_a = inst[8:6];
  assign rt_a = inst[5:3];

  // Register file: no reset, r0 is never written and always reads as zero.
  always_ff @(posedge clk) begin
    if (wb_en && wb_addr != 3'd0) regs[wb_addr] <= wb_data;
  end

  // A same-cycle write-back to a nonzero read address is forwarded.
  assign rs_val = (rs_a == 3'd0) ? '0 : (wb_en && wb_addr == rs_a) ? wb_data : regs[rs_a];
  assign rt_val = (rt_a == 3'd0) ? '0 : (wb_en && wb_addr == rt_a) ? wb_data : regs[rt_a];
  assign rd_val = (rd_a == 3'd0) ? '0 : (wb_en && wb_addr == rd_a) ? wb_data : regs[rd_a];

  always_comb begin
    dec         = '0;
    reads_rs    = 1'b0;
    reads_rt    = 1'b0;
    reads_rd    = 1'b0;
    dec.valid   = 1'b1;
    dec.op      = op;
    dec.rd      = rd_a;
    dec.rs_data = rs_val;
    dec.rt_data = rt_val;
    case (op)
      4'h0: begin
        dec.alu_fn    = inst[2:0];
        dec.reg_write = 1'b1;
        reads_rs      = 1'b1;
        reads_rt      = 1'b1;
      end
      4'h1: begin
        dec.imm       = {{(DATA_W-6){inst[5]}}, inst[5:0]};
        dec.reg_write = 1'b1;
        reads_rs      = 1'b1;
      end
      4'h2: begin
        dec.imm       = {{(DATA_W-6){inst[5]}}, inst[5:0]};
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        reads_rs      = 1'b1;
      end
      4'h3: begin
        dec.imm       = {{(DATA_W-6){inst[5]}}, inst[5:0]};
        dec.mem_write = 1'b1;
        dec.rt_data   = rd_val;
        reads_rs      = 1'b1;
        reads_rd      = 1'b1;
      end
      4'h4: begin
        // BEQ compares by subtraction in execute.
        dec.imm     = {{(DATA_W-6){inst[5]}}, inst[5:0]};
        dec.alu_fn  = 3'd1;
        dec.branch  = 1'b1;
        dec.rt_data = rd_val;
        reads_rs    = 1'b1;
        reads_rd    = 1'b1;
      end
      4'h5: begin
        dec.imm  = {{(DATA_W-12){inst[11]}}, inst[11:0]};
        dec.jump = 1'b1;
      end
      4'h6: begin
        dec.imm       = {{(DATA_W-9){inst[8]}}, inst[8:0]};
        dec.reg_write = 1'b1;
      end
      4'hF:    dec.halt    = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

  assign src_match = (reads_rs && rs_a == out_q.rd) ||
                     (reads_rt && rt_a == out_q.rd) ||
                     (reads_rd && rd_a == out_q.rd);
  assign hazard = out_q.valid && out_q.mem_read && (out_q.rd != 3'd0) &&
                  inst_valid && !flush && (state_q == RUN) && src_match;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    if (state_q == HALTED) begin
      out_d = '0;
    end else if (stall) begin
      out_d = out_q;
    end else if (flush || hazard || !inst_valid) begin
      out_d = '0;
    end else begin
      out_d = dec;
      if (dec.halt) state_d = HALTED;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign valid_o     = out_q.valid;
  assign op_o        = out_q.op;
  assign alu_fn_o    = out_q.alu_fn;
  assign rd_o        = out_q.rd;
  assign rs_data_o   = out_q.rs_data;
  assign rt_data_o   = out_q.rt_data;
  assign imm_o       = out_q.imm;
  assign reg_write_o = out_q.reg_write;
  assign mem_read_o  = out_q.mem_read;
  assign mem_write_o = out_q.mem_write;
  assign branch_o    = out_q.branch;
  assign jump_o      = out_q.jump;
  assign halt_o      = out_q.halt;
  assign illegal_o   = out_q.illegal;
  assign hazard_o    = hazard;

endmodule

// File: tb/tb_decode.sv
// Directed-vector bench for the decode stage; expected values are hand-derived
// from the instruction encodings.
module tb_decode;
  logic        clk, rst;
  logic [15:0] inst;
  logic        inst_valid, stall, flush, wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        valid_o;
  logic [3:0]  op_o;
  logic [2:0]  alu_fn_o, rd_o;
  logic [15:0] rs_data_o, rt_data_o, imm_o;
  logic        reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o;
  logic        halt_o, illegal_o, hazard_o;

  int n_checks = 0;
  int n_fail   = 0;

  decode dut (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid),
    .stall(stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .valid_o(valid_o), .op_o(op_o), .alu_fn_o(alu_fn_o),
    .rd_o(rd_o), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o),
    .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .branch_o(branch_o), .jump_o(jump_o),
    .halt_o(halt_o), .illegal_o(illegal_o), .hazard_o(hazard_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // advance one clock; returns 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] i, input logic v);
    inst       = i;
    inst_valid = v;
  endtask

  initial begin
    rst = 1'b0; inst = '0; inst_valid = 0; stall = 0; flush = 0;
    wb_en = 0; wb_addr = '0; wb_data = '0;
    step(); step();
    check("rst_valid", 16'(valid_o), 16'd0);
    check("rst_op", 16'(op_o), 16'd0);
    check("rst_imm", imm_o, 16'h0000);
    check("rst_hazard", 16'(hazard_o), 16'd0);

    // ADDI r1, r1, 5
    rst = 1'b1;
    drive(16'h1245, 1);
    step();
    check("addi_valid", 16'(valid_o), 16'd1);
    check("addi_op", 16'(op_o), 16'd1);
    check("addi_rd", 16'(rd_o), 16'd1);
    check("addi_imm", imm_o, 16'h0005);
    check("addi_regw", 16'(reg_write_o), 16'd1);
    check("addi_fn", 16'(alu_fn_o), 16'd0);

    // add r1, r2, r2 with same-cycle write-back of r2
    drive(16'h0290, 1);
    wb_en = 1; wb_addr = 3'd2; wb_data = 16'hBEEF;
    step();
    check("byp_rs", rs_data_o, 16'hBEEF);
    check("byp_rt", rt_data_o, 16'hBEEF);
    check("add_op", 16'(op_o), 16'd0);

    // write to r0 then read r0 (also with write in flight)
    drive(16'h0000, 1);
    wb_addr = 3'd0; wb_data = 16'h1234;
    step();
    check("r0_byp", rs_data_o, 16'h0000);
    wb_en = 0;
    step();
    check("r0_read", rs_data_o, 16'h0000);

    // r2 from storage, no bypass
    drive(16'h0290, 1);
    step();
    check("rf_rs", rs_data_o, 16'hBEEF);

    // SW r2, 3(r0): operand B is R[rd]
    drive(16'h3403, 1);
    step();
    check("sw_memw", 16'(mem_write_o), 16'd1);
    check("sw_rt", rt_data_o, 16'hBEEF);
    check("sw_imm", imm_o, 16'h0003);
    check("sw_regw", 16'(reg_write_o), 16'd0);

    // LW r1, -1(r0) then add r1, r1, r1: load-use hazard
    drive(16'h223F, 1);
    step();
    check("lw_memr", 16'(mem_read_o), 16'd1);
    check("lw_imm", imm_o, 16'hFFFF);
    drive(16'h0248, 1);
    #1;
    check("hz_on", 16'(hazard_o), 16'd1);
    step();
    check("hz_bubble", 16'(valid_o), 16'd0);
    check("hz_off", 16'(hazard_o), 16'd0);
    step();
    check("hz_add_valid", 16'(valid_o), 16'd1);
    check("hz_add_op", 16'(op_o), 16'd0);

    // LW r1 followed by LI r7 (no sources) -> no hazard
    drive(16'h223F, 1);
    step();
    drive(16'h6F00, 1);
    #1;
    check("hz_none", 16'(hazard_o), 16'd0);
    step();
    check("li_imm", imm_o, 16'hFF00);
    check("li_rd", 16'(rd_o), 16'd7);
    check("li_valid", 16'(valid_o), 16'd1);

    // JMP, then flush with a valid ADDI
    drive(16'h5FFE, 1);
    step();
    check("jmp_imm", imm_o, 16'hFFFE);
    check("jmp_flag", 16'(jump_o), 16'd1);
    drive(16'h1245, 1);
    flush = 1;
    step();
    check("fl_valid", 16'(valid_o), 16'd0);
    check("fl_jump", 16'(jump_o), 16'd0);
    check("fl_regw", 16'(reg_write_o), 16'd0);
    flush = 0;

    // stall holds ADDI for three cycles while inst changes
    drive(16'h1245, 1);
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(16'h5FFE - 16'(i), 1);
      step();
      check("stl_valid", 16'(valid_o), 16'd1);
      check("stl_op", 16'(op_o), 16'd1);
      check("stl_imm", imm_o, 16'h0005);
    end
    stall = 0;

    // illegal opcode and no-instruction cycle
    drive(16'h7000, 1);
    step();
    check("ill_flag", 16'(illegal_o), 16'd1);
    check("ill_valid", 16'(valid_o), 16'd1);
    check("ill_regw", 16'(reg_write_o), 16'd0);
    drive(16'h1245, 0);
    step();
    check("idle_valid", 16'(valid_o), 16'd0);

    // flush together with HALT keeps the stage running
    drive(16'hF000, 1);
    flush = 1;
    step();
    check("flh_halt", 16'(halt_o), 16'd0);
    flush = 0;
    drive(16'h1245, 1);
    step();
    check("flh_run", 16'(valid_o), 16'd1);

    // async reset mid-cycle with live outputs
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 16'(valid_o), 16'd0);
    check("arst_imm", imm_o, 16'h0000);
    check("arst_regw", 16'(reg_write_o), 16'd0);
    rst = 1'b1;
    step();
    check("arst_resume", 16'(valid_o), 16'd1);

    // HALT: one-cycle halt_o, then dead until reset
    drive(16'hF000, 1);
    step();
    check("halt_flag", 16'(halt_o), 16'd1);
    check("halt_valid", 16'(valid_o), 16'd1);
    for (int i = 0; i < 5; i++) begin
      drive(16'h1245, 1);
      step();
      check("hlt_valid", 16'(valid_o), 16'd0);
      check("hlt_flag", 16'(halt_o), 16'd0);
    end
    #2 rst = 1'b0;
    #1;
    check("hlt_rst_valid", 16'(valid_o), 16'd0);
    rst = 1'b1;
    step();
    check("hlt_resume", 16'(valid_o), 16'd1);
    check("hlt_resume_imm", imm_o, 16'h0005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
